rand_spawn_scheduler: RTL and testbench
=======================================

# rand_spawn_scheduler

Consumes the 16-bit pseudo-random word from the LFSR generator and turns it into a timed stream of spawn requests for the game logic. Each request carries a random lane position and object kind. Request spacing is a random number of game ticks. Requests leave the block on a valid/ready handshake toward the object manager.

## Interface
- `POS_COUNT`, default 10: number of lanes; legal range 8..16.
- `MIN_GAP`, default 16: minimum spacing in ticks; legal range 1..255.
- `GAP_BITS`, default 6: number of random bits added to `MIN_GAP`; legal range 1..8.
- `clk` input 1: single clock.
- `rst` input 1: asynchronous, active-high reset.
- `rnd` input 16: current LFSR word; sampled only at the load and offer edges defined below.
- `enable` input 1: level; allows scheduling.
- `tick` input 1: one-cycle game-tick strobe; the gap counter advances only on cycles where `tick` is high.
- `spawn_ready` input 1: consumer accepts the request.
- `spawn_valid` output 1: request pending.
- `spawn_pos` output 4: lane, in the range 0..POS_COUNT-1.
- `spawn_kind` output 2: object kind.
- `spawn_count` output 8: number of accepted requests; wraps 255→0.
- `busy` output 1: high when the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and OFFER. The reset state is IDLE.
- **IDLE → WAIT** on any edge where `enable`=1.
  - At that edge, `gap_cnt` loads `MIN_GAP + rnd[GAP_BITS-1:0]`.
  - `gap_cnt` is 9 bits wide, so the maximum load is 255+255=510 with no overflow.
- **WAIT behaviour:**
  - If `enable`=0, return to IDLE at the next edge. The counter value is discarded and no request is issued.
  - Else, if `tick`=1 and `gap_cnt`==1, go to OFFER.
  - Else, if `tick`=1, decrement `gap_cnt`.
- **Entry into OFFER** (same edge as the WAIT→OFFER transition):
  - `spawn_kind` ← `rnd[11:10]`.
  - `raw` = `rnd[15:12]`. If `raw` ≥ POS_COUNT, `pos` = `raw` − POS_COUNT; otherwise `pos` = `raw`. One subtraction is sufficient because POS_COUNT ≥ 8.
  - `spawn_pos` ← `pos`, adjusted as described under Configuration.
  - `spawn_valid` ← 1.
- **OFFER behaviour:**
  - `spawn_valid`, `spawn_pos` and `spawn_kind` are held stable until `spawn_valid`&&`spawn_ready` is true at a clock edge.
  - On acceptance:
    - `spawn_count` increments.
    - `last_pos` ← `spawn_pos` and `last_vld` ← 1.
    - `spawn_valid` drops at that edge.
  - After acceptance, if `enable`=1, go to WAIT, reloading `gap_cnt` from the current `rnd` at the same edge. Otherwise go to IDLE.
- `enable` falling while in OFFER does not withdraw the pending request; the handshake always completes first.
- `tick` is ignored in IDLE and in OFFER; ticks seen there are not banked.
- `busy` = (state != IDLE).
- **Reset values:**
  - State = IDLE, `gap_cnt` = 0.
  - `spawn_valid` = 0, `spawn_pos` = 0, `spawn_kind` = 0, `spawn_count` = 0.
  - `last_pos` = 0, `last_vld` = 0.
- Reset asserted mid-WAIT or mid-OFFER clears everything immediately (asynchronously). A pending request is lost and is not counted.

## Timing
- From `enable` rising to entering WAIT: one edge.
- From the tick that brings `gap_cnt` to 1 to `spawn_valid` high: `spawn_valid` is registered on that same edge, so it is visible in the following cycle.
- Minimum spacing between request offers is `MIN_GAP` ticks, counted after acceptance.
- If `spawn_ready` is already high when `spawn_valid` rises, the request is accepted after exactly one cycle of `spawn_valid`.
- If `tick` and acceptance fall in the same cycle, the tick is not counted against the new gap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `RAND_SPAWN_NO_REPEAT_EN`.
- **When defined:** if `last_vld`=1 and `pos`==`last_pos`, the offered position becomes `pos`+1, wrapping from POS_COUNT−1 to 0. The same lane is therefore never offered twice in a row.
- **When undefined:** `spawn_pos` = `pos` unmodified, and `last_pos`/`last_vld` are not implemented.

## Test plan
- **Reset value and first gap:** hold `rnd`=16'hFFFF, `enable`=1, `tick` high every cycle, with defaults. Required: `spawn_valid` rises after 79 ticks; `spawn_pos`=5; `spawn_kind`=3.
- **Position wrap:** with `rnd`=16'hA400, the request is offered with `spawn_pos`=0 and `spawn_kind`=1 when the macro is off.
- **No-repeat:** macro on, `rnd`=16'h5000 on two consecutive offers. Required: the first offer has `spawn_pos`=5 and the second has `spawn_pos`=6. With `rnd`=16'h9000 twice, the positions are 9 and then 0.
- **Backpressure:** hold `spawn_ready`=0 for 20 cycles while `rnd` changes. Required: `spawn_pos` and `spawn_kind` stay constant. When `spawn_ready` rises, `spawn_count` goes 0→1 and `spawn_valid` drops one edge later.
- **Enable drop:** drop `enable` in WAIT. Required: `busy`=0 after one edge and no request is issued. Drop `enable` in OFFER. Required: the request is still accepted, then the FSM goes to IDLE.
- **Counter wrap and async reset:** complete 256 accepts. Required: `spawn_count` reads 0. Pulse `rst` mid-OFFER between clock edges. Required: `spawn_valid`=0 immediately and `spawn_count`=0.

Source files
------------

// File: rtl/rand_spawn_scheduler_if.sv
// Valid/ready spawn request channel from the scheduler (master) to the object manager (slave).
interface rand_spawn_scheduler_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [3:0] spawn_pos;
  logic [1:0] spawn_kind;

  modport master (output spawn_valid, output spawn_pos, output spawn_kind, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_pos, input spawn_kind, output spawn_ready);
endinterface

// File: rtl/rand_spawn_scheduler.sv
// Turns LFSR words into randomly spaced spawn requests (lane + kind) on a valid/ready channel.
// Optional feature macro RAND_SPAWN_NO_REPEAT_EN: never offer the same lane twice in a row.
module rand_spawn_scheduler #(
  parameter int POS_COUNT = 10,
  parameter int MIN_GAP   = 16,
  parameter int GAP_BITS  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   rnd_i,
  input  logic                          enable_i,
  input  logic                          tick_i,
  rand_spawn_scheduler_if.master        spawn,
  output logic [7:0]                    spawn_count_o,
  output logic                          busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] OFFER = 2'd2;

  localparam logic [8:0] MIN_GAP_W = 9'(MIN_GAP);
  localparam logic [4:0] POS_W     = 5'(POS_COUNT);

  logic [1:0] state_q, state_d;
  logic [8:0] gap_q, gap_d;
  logic       valid_q, valid_d;
  logic [3:0] pos_q, pos_d;
  logic [1:0] kind_q, kind_d;
  logic [7:0] count_q, count_d;

  logic [8:0] gap_load;
  logic [3:0] raw_pos;
  logic [3:0] fold_pos;
  logic [3:0] offer_pos;
  logic       accept;
  logic       unused_rnd;

  assign gap_load   = MIN_GAP_W + {{(9 - GAP_BITS){1'b0}}, rnd_i[GAP_BITS-1:0]};
  assign raw_pos    = rnd_i[15:12];
  // POS_COUNT >= 8 keeps the folded value in range after a single subtraction.
  assign fold_pos   = ({1'b0, raw_pos} >= POS_W) ? (raw_pos - POS_W[3:0]) : raw_pos;
  assign accept     = (state_q == OFFER) && valid_q && spawn.spawn_ready;
  assign unused_rnd = ^rnd_i;

`ifdef RAND_SPAWN_NO_REPEAT_EN
  logic [3:0] last_pos_q, last_pos_d;
  logic       last_vld_q, last_vld_d;

  assign offer_pos = (last_vld_q && (fold_pos == last_pos_q))
                     ? (({1'b0, fold_pos} == (POS_W - 5'd1)) ? 4'd0 : (fold_pos + 4'd1))
                     : fold_pos;

  always_comb begin
    last_pos_d = last_pos_q;
    last_vld_d = last_vld_q;
    if (accept) begin
      last_pos_d = pos_q;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pos_q <= 4'd0;
      last_vld_q <= 1'b0;
    end else begin
      last_pos_q <= last_pos_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign offer_pos = fold_pos;
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    pos_d   = pos_q;
    kind_d  = kind_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = WAIT;
          gap_d   = gap_load;
        end
      end
      WAIT: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (tick_i) begin
          if (gap_q == 9'd1) begin
            state_d = OFFER;
            valid_d = 1'b1;
            pos_d   = offer_pos;
            kind_d  = rnd_i[11:10];
          end else begin
            gap_d = gap_q - 9'd1;
          end
        end
      end
      OFFER: begin
        // A pending request always completes, even if enable has dropped.
        if (accept) begin
          count_d = count_q + 8'd1;
          valid_d = 1'b0;
          if (enable_i) begin
            state_d = WAIT;
            gap_d   = gap_load;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= 9'd0;
      valid_q <= 1'b0;
      pos_q   <= 4'd0;
      kind_q  <= 2'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      pos_q   <= pos_d;
      kind_q  <= kind_d;
      count_q <= count_d;
    end
  end

  assign spawn.spawn_valid = valid_q;
  assign spawn.spawn_pos   = pos_q;
  assign spawn.spawn_kind  = kind_q;
  assign spawn_count_o     = count_q;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_rand_spawn_scheduler.sv
// Directed bench for rand_spawn_scheduler at default parameters; expectations follow RAND_SPAWN_NO_REPEAT_EN.
module tb_rand_spawn_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] rnd;
  logic        enable;
  logic        tick;
  logic [7:0]  spawnCount;
  logic        busy;
  int          vectorsApplied = 0;
  int          miscompares = 0;
  int          edges;
  logic        seenValid;

`ifdef RAND_SPAWN_NO_REPEAT_EN
  localparam logic [15:0] SecondFivePos = 16'd6;
  localparam logic [15:0] SecondNinePos = 16'd0;
`else
  localparam logic [15:0] SecondFivePos = 16'd5;
  localparam logic [15:0] SecondNinePos = 16'd9;
`endif

  rand_spawn_scheduler_if spawnIf ();

  rand_spawn_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .rnd_i         (rnd),
    .enable_i      (enable),
    .tick_i        (tick),
    .spawn         (spawnIf),
    .spawn_count_o (spawnCount),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [15:0] r, input logic en, input logic tk, input logic rdy);
    rnd = r;
    enable = en;
    tick = tk;
    spawnIf.spawn_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectorsApplied++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the call until spawn_valid is seen high, bounded by limit.
  task automatic waitValid(input string tag, input int limit, output int edgeCount);
    edgeCount = 0;
    do begin
      stepCycle();
      edgeCount++;
    end while (!spawnIf.spawn_valid && edgeCount < limit);
    checkOutput({tag, "Valid"}, 16'(spawnIf.spawn_valid), 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("rstValid", 16'(spawnIf.spawn_valid), 16'd0);
    checkOutput("rstPos", 16'(spawnIf.spawn_pos), 16'd0);
    checkOutput("rstKind", 16'(spawnIf.spawn_kind), 16'd0);
    checkOutput("rstCount", 16'(spawnCount), 16'd0);
    checkOutput("rstBusy", 16'(busy), 16'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("idleBusy", 16'(busy), 16'd0);

    // First gap: one load edge then 16+63 = 79 ticks.
    applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b0);
    waitValid("firstGap", 200, edges);
    checkOutput("firstGapEdges", 16'(edges), 16'd80);
    checkOutput("firstPos", 16'(spawnIf.spawn_pos), 16'd5);
    checkOutput("firstKind", 16'(spawnIf.spawn_kind), 16'd3);
    checkOutput("firstBusy", 16'(busy), 16'd1);
    checkOutput("firstCount", 16'(spawnCount), 16'd0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'(i * 4951 + 291), 1'b1, 1'b1, 1'b0);
      stepCycle();
      checkOutput("holdPos", 16'(spawnIf.spawn_pos), 16'd5);
      checkOutput("holdKind", 16'(spawnIf.spawn_kind), 16'd3);
    end
    checkOutput("holdValid", 16'(spawnIf.spawn_valid), 16'd1);
    checkOutput("holdCount", 16'(spawnCount), 16'd0);

    applyStimulus(16'hA400, 1'b1, 1'b1, 1'b1);
    stepCycle();
    checkOutput("acceptCount", 16'(spawnCount), 16'd1);
    checkOutput("acceptValid", 16'(spawnIf.spawn_valid), 16'd0);
    checkOutput("acceptBusy", 16'(busy), 16'd1);

    waitValid("wrapPos", 50, edges);
    checkOutput("minGapEdges", 16'(edges), 16'd16);
    checkOutput("wrapPosPos", 16'(spawnIf.spawn_pos), 16'd0);
    checkOutput("wrapPosKind", 16'(spawnIf.spawn_kind), 16'd1);

    // Ready already high: exactly one cycle of valid.
    applyStimulus(16'h5000, 1'b1, 1'b1, 1'b1);
    stepCycle();
    checkOutput("oneCycleValid", 16'(spawnIf.spawn_valid), 16'd0);
    checkOutput("oneCycleCount", 16'(spawnCount), 16'd2);

    waitValid("fiveA", 50, edges);
    checkOutput("fiveAEdges", 16'(edges), 16'd16);
    checkOutput("fiveAPos", 16'(spawnIf.spawn_pos), 16'd5);
    checkOutput("fiveAKind", 16'(spawnIf.spawn_kind), 16'd0);
    stepCycle();
    checkOutput("fiveACount", 16'(spawnCount), 16'd3);
    waitValid("fiveB", 50, edges);
    checkOutput("fiveBPos", 16'(spawnIf.spawn_pos), SecondFivePos);

    applyStimulus(16'h9000, 1'b1, 1'b1, 1'b1);
    stepCycle();
    checkOutput("fiveBCount", 16'(spawnCount), 16'd4);
    waitValid("nineA", 50, edges);
    checkOutput("nineAPos", 16'(spawnIf.spawn_pos), 16'd9);
    stepCycle();
    checkOutput("nineACount", 16'(spawnCount), 16'd5);
    waitValid("nineB", 50, edges);
    checkOutput("nineBPos", 16'(spawnIf.spawn_pos), SecondNinePos);

    // Enable drop while waiting.
    stepCycle();
    checkOutput("nineBCount", 16'(spawnCount), 16'd6);
    checkOutput("waitBusy", 16'(busy), 16'd1);
    applyStimulus(16'h9000, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("dropWaitBusy", 16'(busy), 16'd0);
    seenValid = 1'b0;
    repeat (100) begin
      stepCycle();
      seenValid = seenValid | spawnIf.spawn_valid;
    end
    checkOutput("dropWaitNoReq", 16'(seenValid), 16'd0);
    checkOutput("dropWaitCount", 16'(spawnCount), 16'd6);

    // Enable drop while offering.
    applyStimulus(16'h5000, 1'b1, 1'b1, 1'b0);
    waitValid("dropOffer", 50, edges);
    checkOutput("dropOfferEdges", 16'(edges), 16'd17);
    applyStimulus(16'h5000, 1'b0, 1'b1, 1'b0);
    repeat (3) stepCycle();
    checkOutput("dropOfferValid", 16'(spawnIf.spawn_valid), 16'd1);
    checkOutput("dropOfferBusy", 16'(busy), 16'd1);
    checkOutput("dropOfferPos", 16'(spawnIf.spawn_pos), 16'd5);
    applyStimulus(16'h5000, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("dropOfferCount", 16'(spawnCount), 16'd7);
    checkOutput("dropOfferIdle", 16'(busy), 16'd0);
    checkOutput("dropOfferDone", 16'(spawnIf.spawn_valid), 16'd0);

    // Run accepts up to 256 total.
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 249; i++) begin
      waitValid("wrapLoop", 50, edges);
    end
    checkOutput("wrapLoopEdges", 16'(edges), 16'd17);
    checkOutput("count255", 16'(spawnCount), 16'd255);
    stepCycle();
    checkOutput("countWrap", 16'(spawnCount), 16'd0);

    // Asynchronous reset between edges while offering.
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
    waitValid("rstOffer", 50, edges);
    checkOutput("rstOfferEdges", 16'(edges), 16'd16);
    checkOutput("rstOfferCount", 16'(spawnCount), 16'd0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncValid", 16'(spawnIf.spawn_valid), 16'd0);
    checkOutput("asyncCount", 16'(spawnCount), 16'd0);
    checkOutput("asyncBusy", 16'(busy), 16'd0);
    checkOutput("asyncPos", 16'(spawnIf.spawn_pos), 16'd0);
    #2;
    rst = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("postRstBusy", 16'(busy), 16'd0);
    checkOutput("postRstValid", 16'(spawnIf.spawn_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
